// File: rtl/mode_pattern_gen.sv
// -----------------------------------------------------------------------------
// mode_pattern_gen
//
// Multi-channel valid/ready pattern source. The per-channel datapath is chosen
// at elaboration by MODE:
//   0 = constant CONST_VAL
//   1 = wrapping counter 0..LIMIT
//   2 = walking one (rotate left, starts at 1)
// Each channel runs an IDLE/RUN/HOLD FSM and holds its own WIDTH-bit value
// register. The value advances only on an accepted beat.
//
// Optional feature macro: PATTERN_GEN_STALL_CNT_EN adds the stall_cnt port
// with a saturating 16-bit per-channel count of cycles that are valid but not
// ready.
//
// Ports:
//   clk        in   1               clock
//   rst_n      in   1               synchronous active-low reset
//   en         in   CHANNELS        per-channel enable (level)
//   out_ready  in   CHANNELS        consumer ready
//   out_valid  out  CHANNELS        data valid
//   out_data   out  CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH]
//   wrap       out  CHANNELS        one-cycle pulse after the wrapping beat
//   stall_cnt  out  CHANNELS*16     only with PATTERN_GEN_STALL_CNT_EN
// -----------------------------------------------------------------------------
module mode_pattern_gen #(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 2,
  parameter int               MODE      = 1,
  parameter logic [WIDTH-1:0] CONST_VAL = '0,
  parameter int               LIMIT     = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       wrap
`ifdef PATTERN_GEN_STALL_CNT_EN
  ,
  output logic [CHANNELS*16-1:0]    stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] INIT_V  = (MODE == 0) ? CONST_VAL :
                                         (MODE == 2) ? WIDTH'(1)  : '0;

  // The counter's last value must be representable in WIDTH bits.
  if (MODE == 1 && (LIMIT < 0 || longint'(LIMIT) >= (longint'(1) << WIDTH))) begin : g_bad_limit
    $error("mode_pattern_gen: LIMIT %0d does not fit in WIDTH %0d", LIMIT, WIDTH);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_valid;
    logic             w_accept;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_next_value;
    logic             w_at_last;
    logic             r_wrap;

    // Pattern step: what the value becomes once the current beat is taken,
    // and whether taking it closes a full period of the pattern.
    if (MODE == 0) begin : g_const
      assign w_next_value = CONST_VAL;
      assign w_at_last    = 1'b0;
    end else if (MODE == 1) begin : g_counter
      assign w_at_last    = (r_value == LIMIT_V);
      assign w_next_value = w_at_last ? '0 : r_value + WIDTH'(1);
    end else if (MODE == 2) begin : g_walk
      assign w_at_last    = r_value[WIDTH-1];
      assign w_next_value = {r_value[WIDTH-2:0], r_value[WIDTH-1]};
    end else begin : g_bad_mode
      assign w_next_value = r_value;
      assign w_at_last    = 1'b0;
      $error("mode_pattern_gen: unsupported MODE %0d", MODE);
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
      w_state_nxt = r_state;
      w_valid     = 1'b0;
      w_accept    = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (en[c]) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          w_valid  = 1'b1;
          w_accept = out_ready[c];
          if (!en[c]) w_state_nxt = out_ready[c] ? S_IDLE : S_HOLD;
        end
        S_HOLD: begin
          // Enable reasserting here only chooses where we go after the
          // pending beat is taken; the value stays frozen until then.
          w_valid  = 1'b1;
          w_accept = out_ready[c];
          if (out_ready[c]) w_state_nxt = en[c] ? S_RUN : S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the value register is reset on purpose: out_data must show the
    // pattern's initial value straight out of reset, and a pending beat is
    // discarded rather than resumed.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_value <= INIT_V;
        r_wrap  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_wrap  <= w_accept & w_at_last;
        if (w_accept) r_value <= w_next_value;
      end
    end

    assign out_valid[c]                 = w_valid;
    assign out_data[c*WIDTH +: WIDTH]   = r_value;
    assign wrap[c]                      = r_wrap;

`ifdef PATTERN_GEN_STALL_CNT_EN
    logic [15:0] r_stall;

    // Saturates instead of wrapping so a long stall never reads as a short one.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_stall <= '0;
      end else if (w_valid && !out_ready[c] && r_stall != 16'hFFFF) begin
        r_stall <= r_stall + 16'd1;
      end
    end

    assign stall_cnt[c*16 +: 16] = r_stall;
`endif
  end

endmodule

// File: tb/tb_mode_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_mode_pattern_gen
//
// Drives four instances of mode_pattern_gen (counter LIMIT=5 x2 channels,
// walking one, constant 8'hA5, counter LIMIT=11) from one clock and compares
// every output each cycle against a beat-count reference model.
// -----------------------------------------------------------------------------
module tb_mode_pattern_gen;

  localparam int NU = 5;  // 0,1: c5 ch0/ch1  2: walk  3: const  4: c11

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NU-1:0] en_u;
  logic [NU-1:0] rdy_u;

  logic [1:0] c5_valid, c5_wrap;
  logic [7:0] c5_data;
  logic       wk_valid, wk_wrap;
  logic [3:0] wk_data;
  logic       k_valid, k_wrap;
  logic [7:0] k_data;
  logic       c11_valid, c11_wrap;
  logic [3:0] c11_data;
`ifdef PATTERN_GEN_STALL_CNT_EN
  logic [31:0] c5_stall;
  logic [15:0] wk_stall, k_stall, c11_stall;
`endif

  mode_pattern_gen #(.WIDTH(4), .CHANNELS(2), .MODE(1), .LIMIT(5)) u_c5 (
    .clk(clk), .rst_n(rst_n), .en(en_u[1:0]), .out_ready(rdy_u[1:0]),
    .out_valid(c5_valid), .out_data(c5_data), .wrap(c5_wrap)
`ifdef PATTERN_GEN_STALL_CNT_EN
    , .stall_cnt(c5_stall)
`endif
  );

  mode_pattern_gen #(.WIDTH(4), .CHANNELS(1), .MODE(2)) u_walk (
    .clk(clk), .rst_n(rst_n), .en(en_u[2]), .out_ready(rdy_u[2]),
    .out_valid(wk_valid), .out_data(wk_data), .wrap(wk_wrap)
`ifdef PATTERN_GEN_STALL_CNT_EN
    , .stall_cnt(wk_stall)
`endif
  );

  mode_pattern_gen #(.WIDTH(8), .CHANNELS(1), .MODE(0), .CONST_VAL(8'hA5)) u_const (
    .clk(clk), .rst_n(rst_n), .en(en_u[3]), .out_ready(rdy_u[3]),
    .out_valid(k_valid), .out_data(k_data), .wrap(k_wrap)
`ifdef PATTERN_GEN_STALL_CNT_EN
    , .stall_cnt(k_stall)
`endif
  );

  mode_pattern_gen #(.WIDTH(4), .CHANNELS(1), .MODE(1), .LIMIT(11)) u_c11 (
    .clk(clk), .rst_n(rst_n), .en(en_u[4]), .out_ready(rdy_u[4]),
    .out_valid(c11_valid), .out_data(c11_data), .wrap(c11_wrap)
`ifdef PATTERN_GEN_STALL_CNT_EN
    , .stall_cnt(c11_stall)
`endif
  );

  // Reference model: a unit is "beats accepted so far" plus a valid flag.
  int unsigned m_n     [NU];
  bit          m_valid [NU];
  bit          m_wrap  [NU];
  int unsigned m_stall [NU];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  function automatic int kind(input int u);
    if (u == 3) return 0;
    if (u == 2) return 2;
    return 1;
  endfunction

  function automatic int unsigned period(input int u);
    case (kind(u))
      1:       return (u == 4) ? 12 : 6;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  // Pattern element number n, straight from the pattern definition.
  function automatic logic [15:0] exp_data(input int u, input int unsigned n);
    case (kind(u))
      0:       return 16'h00A5;
      1:       return 16'(n % period(u));
      default: return 16'(1 << (n % period(u)));
    endcase
  endfunction

  function automatic bit is_last(input int u, input int unsigned n);
    if (kind(u) == 0) return 1'b0;
    return (n % period(u)) == period(u) - 1;
  endfunction

  function automatic logic [15:0] obs_data(input int u);
    case (u)
      0:       return {12'h0, c5_data[3:0]};
      1:       return {12'h0, c5_data[7:4]};
      2:       return {12'h0, wk_data};
      3:       return {8'h0, k_data};
      default: return {12'h0, c11_data};
    endcase
  endfunction

  function automatic logic obs_valid(input int u);
    case (u)
      0:       return c5_valid[0];
      1:       return c5_valid[1];
      2:       return wk_valid;
      3:       return k_valid;
      default: return c11_valid;
    endcase
  endfunction

  function automatic logic obs_wrap(input int u);
    case (u)
      0:       return c5_wrap[0];
      1:       return c5_wrap[1];
      2:       return wk_wrap;
      3:       return k_wrap;
      default: return c11_wrap;
    endcase
  endfunction

`ifdef PATTERN_GEN_STALL_CNT_EN
  function automatic logic [15:0] obs_stall(input int u);
    case (u)
      0:       return c5_stall[15:0];
      1:       return c5_stall[31:16];
      2:       return wk_stall;
      3:       return k_stall;
      default: return c11_stall;
    endcase
  endfunction
`endif

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare every output of every unit just after the edge.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    for (int u = 0; u < NU; u++) begin
      if (!rst_n) begin
        m_n[u] = 0; m_valid[u] = 1'b0; m_wrap[u] = 1'b0; m_stall[u] = 0;
      end else begin
        bit acc;
        acc       = m_valid[u] && rdy_u[u];
        m_wrap[u] = acc && is_last(u, m_n[u]);
        if (m_valid[u] && !rdy_u[u] && m_stall[u] < 65535) m_stall[u]++;
        if (acc) m_n[u]++;
        m_valid[u] = en_u[u] || (m_valid[u] && !rdy_u[u]);
      end
    end
    #1;
    for (int u = 0; u < NU; u++) begin
      check($sformatf("valid[u%0d]", u), {15'h0, obs_valid(u)}, {15'h0, m_valid[u]});
      check($sformatf("data[u%0d]", u),  obs_data(u), exp_data(u, m_n[u]));
      check($sformatf("wrap[u%0d]", u),  {15'h0, obs_wrap(u)},  {15'h0, m_wrap[u]});
`ifdef PATTERN_GEN_STALL_CNT_EN
      check($sformatf("stall[u%0d]", u), obs_stall(u), 16'(m_stall[u]));
`endif
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en_u = '0; rdy_u = '0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int seq [7];
    seq = '{0, 1, 2, 3, 4, 5, 0};

    // Reset state: idle, initial values.
    rst_n = 1'b0; en_u = '0; rdy_u = '0;
    cycle();
    cycle();
    check("rst_valid_c5", {14'h0, c5_valid}, 16'h0);
    check("rst_data_walk", {12'h0, wk_data}, 16'h1);
    check("rst_data_const", {8'h0, k_data}, 16'h00A5);
    rst_n = 1'b1;

    // Counter LIMIT=5 streaming: 0..5 then 0, wrap only after 5 accepted.
    en_u[0] = 1'b1; rdy_u[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cycle();
      check($sformatf("c5_seq%0d", k), {12'h0, c5_data[3:0]}, 16'(seq[k]));
      check($sformatf("c5_wrap%0d", k), {15'h0, c5_wrap[0]}, (k == 6) ? 16'h1 : 16'h0);
    end

    // Walking one with a 3-cycle stall on value 2, then 4, 8, 1 + wrap.
    do_reset();
    en_u[2] = 1'b1; rdy_u[2] = 1'b1;
    cycle();
    cycle();
    check("walk_at2", {12'h0, wk_data}, 16'h2);
    rdy_u[2] = 1'b0;
    repeat (3) cycle();
    check("walk_stall_data", {12'h0, wk_data}, 16'h2);
    check("walk_stall_valid", {15'h0, wk_valid}, 16'h1);
`ifdef PATTERN_GEN_STALL_CNT_EN
    check("walk_stall_cnt", wk_stall, 16'd3);
`endif
    rdy_u[2] = 1'b1;
    cycle(); check("walk_4", {12'h0, wk_data}, 16'h4);
    cycle(); check("walk_8", {12'h0, wk_data}, 16'h8);
    cycle(); check("walk_1", {12'h0, wk_data}, 16'h1);
    check("walk_wrap", {15'h0, wk_wrap}, 16'h1);

    // Counter: drop en while 7 is pending unaccepted -> HOLD, then resume at 8.
    do_reset();
    en_u[4] = 1'b1; rdy_u[4] = 1'b0;
    cycle();
    rdy_u[4] = 1'b1;
    repeat (7) cycle();
    en_u[4] = 1'b0; rdy_u[4] = 1'b0;
    repeat (2) cycle();
    check("hold_valid", {15'h0, c11_valid}, 16'h1);
    check("hold_data", {12'h0, c11_data}, 16'h7);
    en_u[4] = 1'b1;
    cycle();
    check("hold_en_data", {12'h0, c11_data}, 16'h7);
    en_u[4] = 1'b0; rdy_u[4] = 1'b1;
    cycle();
    check("hold_idle", {15'h0, c11_valid}, 16'h0);
    en_u[4] = 1'b1; rdy_u[4] = 1'b0;
    cycle();
    check("resume_data", {12'h0, c11_data}, 16'h8);

    // Constant with random ready.
    do_reset();
    en_u[3] = 1'b1;
    repeat (30) begin
      rdy_u[3] = 1'($urandom);
      cycle();
    end

    // Channel independence: ch0 stalled, ch1 streaming.
    do_reset();
    en_u[1:0] = 2'b11; rdy_u[1:0] = 2'b10;
    repeat (10) cycle();
    check("indep_ch0", {12'h0, c5_data[3:0]}, 16'h0);
    check("indep_ch1", {12'h0, c5_data[7:4]}, 16'h3);

    // Reset mid-stream.
    en_u = '1;
    repeat (10) begin
      rdy_u = NU'($urandom);
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    check("mid_rst_valid", {11'h0, c5_valid, wk_valid, k_valid, c11_valid}, 16'h0);
    check("mid_rst_c11", {12'h0, c11_data}, 16'h0);
`ifdef PATTERN_GEN_STALL_CNT_EN
    check("mid_rst_stall", c5_stall[15:0], 16'h0);
`endif
    rst_n = 1'b1;

    // Random traffic with occasional resets.
    repeat (1500) begin
      en_u  = NU'($urandom);
      rdy_u = NU'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n = 1'b1;

`ifdef PATTERN_GEN_STALL_CNT_EN
    // Stall counter saturation.
    do_reset();
    en_u = '1; rdy_u = '0;
    repeat (70000) cycle();
    check("stall_sat", c5_stall[15:0], 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mode_pattern_gen.md
# mode_pattern_gen

Parametrised multi-channel pattern source whose per-channel datapath is chosen at elaboration time by a `MODE` generate selection: constant, wrapping counter, or walking-one. It generalises the constant-driver generate blocks into a width/channel-scalable, handshaked sequential source. It sits at the front of block-level test and bring-up datapaths, feeding valid/ready consumers.

## Interface
- `WIDTH`, default 8, data width per channel (≥2).
- `CHANNELS`, default 2, number of independent channels (≥1).
- `MODE`, default 1:
  - 0 = constant
  - 1 = wrapping counter
  - 2 = walking one
  - Any other value is an elaboration error (`$error` in the generate else branch).
- `CONST_VAL`, default 0, value driven in MODE 0.
- `LIMIT`, default 255, last counter value in MODE 1; must be < 2**WIDTH, checked at elaboration.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `en`  in  CHANNELS  per-channel enable, level-sensitive.
- `out_ready`  in  CHANNELS  consumer ready.
- `out_valid`  out  CHANNELS  data valid.
- `out_data`  out  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- `wrap`  out  CHANNELS  one-cycle pulse when the pattern wraps.
- `stall_cnt`  out  CHANNELS*16  present only with `PATTERN_GEN_STALL_CNT_EN`.

## Operation
- Each channel has its own FSM with states IDLE, RUN and HOLD, plus a WIDTH-bit value register.
- IDLE: `out_valid`=0; `en`=1 → RUN.
- RUN: `out_valid`=1.
  - Accept (`out_valid`&`out_ready`) advances the value.
  - `en`=0 with accept → IDLE.
  - `en`=0 without accept → HOLD.
- HOLD: `out_valid`=1; `out_data` and the value are frozen until accepted.
  - Accept → IDLE.
  - `en` reasserting in HOLD does not alter the value.
  - Accept with `en`=1 → RUN.
- Valid never drops while unaccepted; data never changes while valid and unaccepted.
- MODE 0: value is always `CONST_VAL`; `wrap` stays 0.
- MODE 1: value runs 0,1,…,`LIMIT`, then 0. Accepting `LIMIT` loads 0 and pulses `wrap`. Arithmetic is unsigned modulo `LIMIT`+1; no overflow past `LIMIT`.
- MODE 2: value runs 1,2,4,…,2**(WIDTH-1), then 1 (rotate left). Accepting MSB-set pulses `wrap`.
- The value is retained across IDLE; re-enabling resumes from the next unsent value. Only reset restores the initial value.
- Channels are fully independent; simultaneous events on different channels do not interact.

## Timing
- Reset (`rst_n`=0 at a `clk` edge):
  - State IDLE, `out_valid`=0, `wrap`=0.
  - Value loads its initial value: `CONST_VAL` / 0 / 1 for MODE 0 / 1 / 2.
  - `out_data` equals that initial value.
- Reset mid-transfer discards the pending beat; no `wrap` pulse is emitted.
- Latency: `en` high at edge N → `out_valid`=1 after edge N (visible in cycle N+1).
- Accept at edge M → next value on `out_data` after edge M. Sustained ready gives one beat per cycle.
- `wrap` is registered: it is high for exactly the cycle following the accepting edge.
- `out_data` is a register output; no combinational path from `out_ready` or `en` to any output.

## Configuration
- `PATTERN_GEN_STALL_CNT_EN` defined:
  - `stall_cnt` port exists. Channel c counts cycles with `out_valid`=1 and `out_ready`=0.
  - Counter is 16-bit unsigned and saturates at 16'hFFFF. Reset value is 0; it is never cleared otherwise.
- Undefined: port and counters are absent; behaviour is otherwise identical.

## Test plan
- MODE=1, WIDTH=4, LIMIT=5, `en`=1, `out_ready`=1 → `out_data` 0,1,2,3,4,5,0; `wrap` high only in the cycle after 5 is accepted.
- MODE=2, WIDTH=4, ready held low 3 cycles on value 2 → `out_data` stays 2 with `out_valid`=1; `stall_cnt`=3 (macro on). Resumes 4,8,1 with `wrap` after 8.
- MODE=1: `en` drops while value 7 is pending with ready=0 → HOLD keeps 7 valid. Accept → IDLE. Re-enable → first beat is 8.
- MODE=0, CONST_VAL=8'hA5, random ready → every accepted beat is 8'hA5; `wrap` never asserts.
- CHANNELS=2, ch0 stalled and ch1 streaming → ch1 sequence is unaffected. `rst_n`=0 mid-stream → next cycle `out_valid`=0, values are initial, `stall_cnt`=0.
- Stall counter saturation (macro on): ready=0 for 70000 cycles → `stall_cnt` holds 16'hFFFF.
